// File: rtl/adc_serial_reader_if.sv
// Parallel sample bus from the serial ADC front-end.
// Producer drives x/data_valid/frame_err; the tracker consumes them.
interface adc_serial_reader_if;
   logic [11:0] x;
   logic        data_valid;
   logic        frame_err;

   modport master (
      output x,
      output data_valid,
      output frame_err
   );

   modport slave (
      input x,
      input data_valid,
      input frame_err
   );
endinterface

// File: rtl/adc_serial_reader.sv
// 12-bit serial ADC reader: drives CS/SCLK, shifts in 16-bit frames,
// presents each conversion as a parallel word with a one-cycle strobe.
module adc_serial_reader #(
   parameter int CLK_DIV       = 2,
   parameter int SAMPLE_PERIOD = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic adc_sdata,
   output logic adc_cs_n,
   output logic adc_sclk,
   adc_serial_reader_if.master smp
);

   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
   localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      DONE
   } state_t;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic [HW-1:0] hcnt;
   logic [4:0]    bcnt;
   logic [15:0]   shreg;
   logic          hend;

   assign hend = (hcnt == H_LAST);

   // Conversion-rate timer; parked at zero so re-enable starts at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
      end else if (!enable) begin
         pcnt <= '0;
      end else if (pcnt == P_LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   // Frame sequencer; every output is registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         adc_cs_n       <= 1'b1;
         adc_sclk       <= 1'b1;
         hcnt           <= '0;
         bcnt           <= '0;
         shreg          <= '0;
         smp.x          <= '0;
         smp.data_valid <= 1'b0;
         smp.frame_err  <= 1'b0;
      end else begin
         smp.data_valid <= 1'b0;
         smp.frame_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (enable && pcnt == '0) begin
                  state    <= SETUP;
                  adc_cs_n <= 1'b0;
                  hcnt     <= '0;
               end
            end
            SETUP: begin
               if (hend) begin
                  state    <= SHIFT;
                  adc_sclk <= 1'b0;
                  hcnt     <= '0;
                  bcnt     <= '0;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            SHIFT: begin
               if (!hend) begin
                  hcnt <= hcnt + 1'b1;
               end else begin
                  hcnt <= '0;
                  if (!adc_sclk) begin
                     adc_sclk <= 1'b1;
                     shreg    <= {shreg[14:0], adc_sdata};
                     bcnt     <= bcnt + 1'b1;
                  end else if (bcnt == 5'd16) begin
                     state          <= DONE;
                     adc_cs_n       <= 1'b1;
                     smp.x          <= shreg[11:0];
                     smp.data_valid <= 1'b1;
                     smp.frame_err  <= |shreg[15:12];
                  end else begin
                     adc_sclk <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: default timing instance plus
// a CLK_DIV=1 / SAMPLE_PERIOD=36 instance, each fed by an ADC model.
module tb_adc_serial_reader;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rst0, rst1, en0, en1;
   logic sd0 = 1'b0;
   logic sd1 = 1'b0;
   logic cs0, sc0, cs1, sc1;
   logic [15:0] w0, w1, c0, c1;
   logic [4:0]  k0 = '0;
   logic [4:0]  k1 = '0;

   adc_serial_reader_if s0 ();
   adc_serial_reader_if s1 ();

   adc_serial_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) u0 (
      .clk(clk), .rst(rst0), .enable(en0), .adc_sdata(sd0),
      .adc_cs_n(cs0), .adc_sclk(sc0), .smp(s0)
   );

   adc_serial_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(36)) u1 (
      .clk(clk), .rst(rst1), .enable(en1), .adc_sdata(sd1),
      .adc_cs_n(cs1), .adc_sclk(sc1), .smp(s1)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Cycle stamp for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model 0: latch word at CS fall, next bit on each SCLK fall.
   always @(negedge cs0) begin
      k0 = '0;
      c0 = w0;
   end
   always @(negedge sc0) begin
      if (cs0 === 1'b0 && k0 < 5'd16) begin
         sd0 = c0[4'd15 - k0[3:0]];
         k0  = k0 + 5'd1;
      end
   end

   // ADC model 1, same behaviour.
   always @(negedge cs1) begin
      k1 = '0;
      c1 = w1;
   end
   always @(negedge sc1) begin
      if (cs1 === 1'b0 && k1 < 5'd16) begin
         sd1 = c1[4'd15 - k1[3:0]];
         k1  = k1 + 5'd1;
      end
   end

   int fall0 = 0, rise0 = 0, dvc0 = 0, pdv0 = 0;
   int low0 = 0, high0 = 0, nr0 = 0, ndv0 = 0, dup0 = 0;
   logic pcs0 = 1'b1, psc0 = 1'b1, pdv_0 = 1'b0;
   int fall1 = 0, rise1 = 0, dvc1 = 0, pdv1 = 0;
   int low1 = 0, high1 = 0, nr1 = 0, ndv1 = 0, dup1 = 0;
   logic pcs1 = 1'b1, psc1 = 1'b1, pdv_1 = 1'b0;

   // Edge/strobe timestamps for instance 0.
   always @(negedge clk) begin
      if (pcs0 === 1'b1 && cs0 === 1'b0) begin
         fall0 = cyc;
         nr0   = 0;
         high0 = cyc - rise0;
      end
      if (pcs0 === 1'b0 && cs0 === 1'b1) begin
         rise0 = cyc;
         low0  = cyc - fall0;
      end
      if (cs0 === 1'b0 && psc0 === 1'b0 && sc0 === 1'b1) nr0++;
      if (s0.data_valid === 1'b1) begin
         pdv0 = dvc0;
         dvc0 = cyc;
         ndv0++;
         if (pdv_0 === 1'b1) dup0++;
      end
      pcs0  = cs0;
      psc0  = sc0;
      pdv_0 = s0.data_valid;
   end

   // Edge/strobe timestamps for instance 1.
   always @(negedge clk) begin
      if (pcs1 === 1'b1 && cs1 === 1'b0) begin
         fall1 = cyc;
         nr1   = 0;
         high1 = cyc - rise1;
      end
      if (pcs1 === 1'b0 && cs1 === 1'b1) begin
         rise1 = cyc;
         low1  = cyc - fall1;
      end
      if (cs1 === 1'b0 && psc1 === 1'b0 && sc1 === 1'b1) nr1++;
      if (s1.data_valid === 1'b1) begin
         pdv1 = dvc1;
         dvc1 = cyc;
         ndv1++;
         if (pdv_1 === 1'b1) dup1++;
      end
      pcs1  = cs1;
      psc1  = sc1;
      pdv_1 = s1.data_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_dv0(input string tag);
      int n;
      for (n = 0; n < 400; n++) begin
         step();
         if (s0.data_valid === 1'b1) break;
      end
      chk(tag, 32'(n < 400), 1);
   endtask

   task automatic wait_dv1(input string tag);
      int n;
      for (n = 0; n < 200; n++) begin
         step();
         if (s1.data_valid === 1'b1) break;
      end
      chk(tag, 32'(n < 200), 1);
   endtask

   task automatic wait_bit0(input string tag, input int b);
      int n;
      for (n = 0; n < 400; n++) begin
         step();
         if (cs0 === 1'b0 && nr0 == b) break;
      end
      chk(tag, 32'(n < 400), 1);
   endtask

   int bad;
   int nd;

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      en0  = 1'b1;
      en1  = 1'b1;
      w0   = 16'h0ABC;
      w1   = 16'h05A5;
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
      step();
      step();
      chk("rst_cs", 32'(cs0), 1);
      chk("rst_sclk", 32'(sc0), 1);
      chk("rst_x", 32'(s0.x), 0);
      chk("rst_dv", 32'(s0.data_valid), 0);
      chk("rst_fe", 32'(s0.frame_err), 0);

      rst0 = 1'b1;
      wait_dv0("dv_abc");
      chk("x_abc", 32'(s0.x), 'hABC);
      chk("fe_abc", 32'(s0.frame_err), 0);
      chk("lat_abc", dvc0 - fall0, 66);
      chk("cslow_abc", low0, 66);
      chk("rises_abc", nr0, 16);
      chk("cs_at_dv", 32'(cs0), 1);
      w0 = 16'h0000;
      step();
      chk("dv_one_cyc", 32'(s0.data_valid), 0);
      chk("x_hold", 32'(s0.x), 'hABC);

      wait_dv0("dv_000");
      chk("x_000", 32'(s0.x), 'h000);
      chk("gap_000", dvc0 - pdv0, 100);
      chk("rises_000", nr0, 16);
      w0 = 16'h0FFF;
      wait_dv0("dv_fff");
      chk("x_fff", 32'(s0.x), 'hFFF);
      chk("fe_fff", 32'(s0.frame_err), 0);
      chk("gap_fff", dvc0 - pdv0, 100);
      w0 = 16'h0800;
      wait_dv0("dv_800");
      chk("x_800", 32'(s0.x), 'h800);
      chk("gap_800", dvc0 - pdv0, 100);
      chk("cslow_800", low0, 66);

      w0 = 16'h8123;
      wait_dv0("dv_123");
      chk("x_123", 32'(s0.x), 'h123);
      chk("fe_123", 32'(s0.frame_err), 1);
      step();
      chk("fe_one_cyc", 32'(s0.frame_err), 0);

      w0 = 16'h0456;
      wait_bit0("bit8", 8);
      en0 = 1'b0;
      wait_dv0("dv_drop");
      chk("x_drop", 32'(s0.x), 'h456);
      chk("gap_drop", dvc0 - pdv0, 100);
      nd  = ndv0;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         step();
         if (cs0 !== 1'b1 || sc0 !== 1'b1) bad++;
      end
      chk("quiet_off", bad, 0);
      chk("no_dv_off", ndv0, nd);

      w0  = 16'h0777;
      en0 = 1'b1;
      step();
      chk("reen_cs", 32'(cs0), 0);
      chk("reen_sclk", 32'(sc0), 1);

      wait_bit0("bit10", 10);
      nd   = ndv0;
      rst0 = 1'b0;
      #1;
      chk("arst_cs", 32'(cs0), 1);
      chk("arst_sclk", 32'(sc0), 1);
      chk("arst_x", 32'(s0.x), 0);
      chk("arst_dv", 32'(s0.data_valid), 0);
      step();
      step();
      w0   = 16'h0321;
      rst0 = 1'b1;
      wait_dv0("dv_321");
      chk("x_321", 32'(s0.x), 'h321);
      chk("lat_321", dvc0 - fall0, 66);
      chk("no_abort_dv", ndv0, nd + 1);

      rst1 = 1'b1;
      wait_dv1("dv_5a5");
      chk("x_5a5", 32'(s1.x), 'h5A5);
      chk("fe_5a5", 32'(s1.frame_err), 0);
      chk("lat_5a5", dvc1 - fall1, 33);
      chk("rises_5a5", nr1, 16);
      chk("cslow_5a5", low1, 33);
      wait_dv1("dv_5a5_b");
      chk("x_5a5_b", 32'(s1.x), 'h5A5);
      chk("gap_36", dvc1 - pdv1, 36);
      chk("cshigh_3", high1, 3);

      chk("dup_dv0", dup0, 0);
      chk("dup_dv1", dup1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_serial_reader.md
# adc_serial_reader

Front-end that reads a 12-bit serial ADC (16-SCLK frame: 4 leading zeros, then 12 data bits MSB first) and presents each conversion as a parallel word `x` with a one-cycle `data_valid` strobe. It is the producer side of the `x`/`data_valid` interface consumed by `TR`, and it replaces the bench-generated sample stream in the TR/TR_pulse tracking chain. It runs in the 50 MHz `clk` domain and generates the ADC chip-select and serial clock itself.

## Interface
- `CLK_DIV`, 2: `clk` cycles per SCLK half-period. SCLK = clk/(2·CLK_DIV). Legal range ≥1.
- `SAMPLE_PERIOD`, 100: `clk` cycles between conversion starts. Must be ≥ 33·CLK_DIV+3.

Ports:
- `clk`  in  1  system clock, 50 MHz, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  level; 1 = run periodic conversions
- `adc_sdata`  in  1  ADC serial data; ADC updates it on SCLK falling edge
- `adc_cs_n`  out  1  ADC chip select, active low
- `adc_sclk`  out  1  ADC serial clock; idles high
- `x`  out  12  last received sample, held between strobes
- `data_valid`  out  1  one-cycle strobe; `x` is valid in that cycle
- `frame_err`  out  1  one-cycle strobe, coincident with `data_valid`, when any leading bit was 1

## Operation
- Reset (`rst`=0, async): `adc_cs_n`=1, `adc_sclk`=1, `x`=0, `data_valid`=0, `frame_err`=0, period counter=0, state IDLE. Effect is immediate, including mid-frame; the aborted frame produces no strobe.
- Period counter `pcnt`: counts 0..SAMPLE_PERIOD-1 and wraps while `enable`=1; held at 0 while `enable`=0.
- States:
  - IDLE: `adc_cs_n`=1, `adc_sclk`=1. When `enable`=1 and `pcnt`=0 → SETUP.
  - SETUP: `adc_cs_n`=0, `adc_sclk`=1 for CLK_DIV cycles → SHIFT.
  - SHIFT: 16 bit periods; each is CLK_DIV cycles with `adc_sclk`=0, then CLK_DIV cycles with `adc_sclk`=1. `adc_sdata` is shifted into a 16-bit register on the clk edge that drives `adc_sclk` 0→1. After the 16th bit's high phase → DONE.
  - DONE (one cycle): `adc_cs_n`=1; `x` ← shift[11:0]; `data_valid`=1; `frame_err`=1 if shift[15:12]≠0. → IDLE.
- `x` is updated even on a frame error; consumers decide whether to use it.
- `enable` falling mid-frame: current frame completes and strobes normally; no further starts. `enable` rising: first SETUP on the next cycle (pcnt=0).
- Bit counter is 5 bits (0..16); half-period counter sized for CLK_DIV. No wrap of `x`; bits are taken verbatim.
- `adc_sdata` is sampled directly (source-synchronous, ≥CLK_DIV cycles of settling); no synchronizer.

## Timing
- All outputs registered; no combinational input→output path.
- `adc_cs_n` falling to `data_valid` high: (1+2·16)·CLK_DIV cycles = 66 at defaults; `data_valid` coincides with `adc_cs_n` rising.
- `adc_cs_n` low time: 33·CLK_DIV cycles. Minimum `adc_cs_n` high time between frames: SAMPLE_PERIOD − 33·CLK_DIV ≥ 3 cycles.
- Strobe spacing in steady state: exactly SAMPLE_PERIOD cycles (100 → 500 kSPS).
- `data_valid` and `frame_err` never high for more than one consecutive cycle.
- SCLK duty cycle exactly 50 %; first falling edge CLK_DIV cycles after `adc_cs_n` falls.

## Test plan
- ADC model returns 16'h0ABC, `enable`=1 from reset release → `x`=12'hABC, `data_valid` 1 cycle, `frame_err`=0, first strobe 66 cycles after first `adc_cs_n` fall.
- Continuous run, samples 0x000, 0xFFF, 0x800 → strobes exactly 100 cycles apart, `x` matches each, 16 SCLK rising edges per `adc_cs_n` low window of 66 cycles.
- ADC returns 16'h8123 → `x`=12'h123, `data_valid`=1 and `frame_err`=1 in same cycle.
- `enable` dropped at bit 8 of a frame → that frame still strobes; `adc_cs_n` stays 1 and no SCLK activity afterward; re-enable → SETUP next cycle.
- `rst` pulsed low at bit 10 → same-time `adc_cs_n`=1, `adc_sclk`=1, `x`=0, no strobe for the aborted frame; normal frame after release.
- CLK_DIV=1, SAMPLE_PERIOD=36 → valid 0x5A5 received, strobes 36 cycles apart, `adc_cs_n` high 3 cycles between frames.
